pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage; the next generation of the single-register PC.
- Selects the next PC from trap, branch, jump/return or sequential increment.
- Buffers a redirect that arrives while fetch is stalled and applies it when the stall releases.
- Keeps a small circular return-address stack (RAS) for call/return.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/ras_stack.sv | 60 ++++++
 rtl/pc_gen.sv | 160 ++++++++++++++++
 tb/tb_pc_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
// Redirect sources are ordered so a numeric compare gives priority.
package pc_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } src_e;

  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0080;
  localparam int          DEF_INC      = 4;

  // A new request may replace a buffered one of equal or lower rank.
  function automatic logic may_replace(src_e nw, src_e cur);
    return (nw != SRC_NONE) &&
           ((cur == SRC_NONE) || (nw >= cur));
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: the oldest entry is overwritten
// when full, and push+pop together replaces the top in place.
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clr_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   top_idx;
  logic            do_pop;

  assign top_idx = ptr_q - 1'b1;
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;

  // Pointer/count/storage update; ptr_q is the next free slot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (do_pop && push_i) begin
      mem_q[top_idx] <= data_i;
    end else if (push_i) begin
      mem_q[ptr_q] <= data_i;
      ptr_q        <= ptr_q + 1'b1;
      if (!full_o) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (do_pop) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised redirects,
// a stall-time redirect buffer and a return-address stack.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              INC       = DEF_INC,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic            trap_i,
  output logic [XLEN-1:0] pc_o,
  output logic            redirect_pending_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] pc_d;

  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;

  src_e            new_src;
  logic [XLEN-1:0] new_tgt;
  logic            new_push;
  logic            new_pop;

  src_e            pend_src_q;
  logic [XLEN-1:0] pend_tgt_q;
  logic [XLEN-1:0] pend_val_q;
  logic            pend_push_q;
  logic            pend_pop_q;

  logic            ras_push;
  logic            ras_pop;
  logic            ras_clr;
  logic [XLEN-1:0] push_val;

  logic            adv;
  logic            cap;

  assign pc_inc = pc_q + XLEN'(INC);
  assign adv    = start_i && !stall_i;
  assign cap    = start_i && stall_i &&
                  may_replace(new_src, pend_src_q);

  // Pick this cycle's redirect and resolve its target/RAS action.
  always_comb begin
    new_src  = SRC_NONE;
    new_tgt  = pc_inc;
    new_push = 1'b0;
    new_pop  = 1'b0;
    priority case (1'b1)
      trap_i: begin
        new_src = SRC_TRAP;
        new_tgt = TRAP_VEC;
      end
      br_taken_i: begin
        new_src = SRC_BR;
        new_tgt = br_target_i;
      end
      jmp_i: begin
        new_src  = SRC_JMP;
        new_tgt  = jmp_target_i;
        new_push = call_i;
        if (ret_i && !ras_empty) begin
          new_tgt = ras_top;
          new_pop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next PC on an advance: new redirect, then buffered, then +INC.
  always_comb begin
    pc_d     = pc_inc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_clr  = 1'b0;
    push_val = pc_inc;
    if (new_src != SRC_NONE) begin
      pc_d     = new_tgt;
      ras_push = new_push;
      ras_pop  = new_pop;
      ras_clr  = (new_src == SRC_TRAP);
    end else if (pend_src_q != SRC_NONE) begin
      pc_d     = pend_tgt_q;
      ras_push = pend_push_q;
      ras_pop  = pend_pop_q;
      ras_clr  = (pend_src_q == SRC_TRAP);
      push_val = pend_val_q;
    end
  end

  // PC register moves only on advance cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q <= RESET_VEC;
    end else if (adv) begin
      pc_q <= pc_d;
    end
  end

  // Redirect buffer: filled while stalled, drained on any advance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_src_q  <= SRC_NONE;
      pend_tgt_q  <= '0;
      pend_val_q  <= '0;
      pend_push_q <= 1'b0;
      pend_pop_q  <= 1'b0;
    end else if (adv) begin
      pend_src_q  <= SRC_NONE;
      pend_push_q <= 1'b0;
      pend_pop_q  <= 1'b0;
    end else if (cap) begin
      pend_src_q  <= new_src;
      pend_tgt_q  <= new_tgt;
      pend_val_q  <= pc_inc;
      pend_push_q <= new_push;
      pend_pop_q  <= new_pop;
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (adv && ras_push),
    .pop_i   (adv && ras_pop),
    .clr_i   (adv && ras_clr),
    .data_i  (push_val),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  assign pc_o               = pc_q;
  assign redirect_pending_o = (pend_src_q != SRC_NONE);
  assign ras_empty_o        = ras_empty;
  assign ras_full_o         = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a queue-based reference model
// checked every cycle plus literal expectations along the way.
module tb_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stall_i;
  logic        br_taken_i, jmp_i, call_i, ret_i, trap_i;
  logic [31:0] br_target_i, jmp_target_i;
  logic [31:0] pc_o;
  logic        redirect_pending_o, ras_empty_o, ras_full_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  pc_gen dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .start_i            (start_i),
    .stall_i            (stall_i),
    .br_taken_i         (br_taken_i),
    .br_target_i        (br_target_i),
    .jmp_i              (jmp_i),
    .jmp_target_i       (jmp_target_i),
    .call_i             (call_i),
    .ret_i              (ret_i),
    .trap_i             (trap_i),
    .pc_o               (pc_o),
    .redirect_pending_o (redirect_pending_o),
    .ras_empty_o        (ras_empty_o),
    .ras_full_o         (ras_full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: PC, one pending slot, RAS as a bounded queue.
  logic [31:0] m_pc   = '0;
  int          m_pp   = 0;
  logic [31:0] m_ptgt = '0;
  logic [31:0] m_pval = '0;
  bit          m_ppu  = 0;
  bit          m_ppo  = 0;
  logic [31:0] m_ras[$];

  task automatic m_apply(int p, logic [31:0] t, bit pu, bit po,
                         logic [31:0] v);
    m_pc = t;
    if (p == 3) m_ras.delete();
    if (po) void'(m_ras.pop_back());
    if (pu) begin
      m_ras.push_back(v);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
  endtask

  always @(posedge clk_i or negedge rst_i) begin
    int          p;
    logic [31:0] t;
    bit          pu, po;
    if (!rst_i) begin
      m_pc = '0;
      m_pp = 0;
      m_ras.delete();
    end else if (start_i) begin
      p = 0; t = '0; pu = 0; po = 0;
      if (trap_i) begin
        p = 3; t = 32'h80;
      end else if (br_taken_i) begin
        p = 2; t = br_target_i;
      end else if (jmp_i) begin
        p = 1; t = jmp_target_i; pu = call_i;
        if (ret_i && m_ras.size() > 0) begin
          t = m_ras[$]; po = 1;
        end
      end
      if (!stall_i) begin
        if (p > 0) m_apply(p, t, pu, po, m_pc + 32'd4);
        else if (m_pp > 0) m_apply(m_pp, m_ptgt, m_ppu, m_ppo, m_pval);
        else m_pc = m_pc + 32'd4;
        m_pp = 0;
      end else if (p > 0 && (m_pp == 0 || p >= m_pp)) begin
        m_pp = p; m_ptgt = t; m_ppu = pu; m_ppo = po;
        m_pval = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && chk_en) begin
      chk("m_pc", pc_o, m_pc);
      chk("m_pend", {31'd0, redirect_pending_o}, {31'd0, m_pp != 0});
      chk("m_empty", {31'd0, ras_empty_o}, {31'd0, m_ras.size() == 0});
      chk("m_full", {31'd0, ras_full_o}, {31'd0, m_ras.size() == 4});
    end
  end

  task automatic set_in(bit st, bit sl, bit br, logic [31:0] bt,
                        bit j, logic [31:0] jt, bit c, bit r, bit tr);
    start_i = st; stall_i = sl; br_taken_i = br; br_target_i = bt;
    jmp_i = j; jmp_target_i = jt; call_i = c; ret_i = r; trap_i = tr;
  endtask

  task automatic idle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pend", {31'd0, redirect_pending_o}, 32'd0);
    chk("rst_empty", {31'd0, ras_empty_o}, 32'd1);
    chk("rst_full", {31'd0, ras_full_o}, 32'd0);
    rst_i = 1'b1;
    chk_en = 1;
    idle();
    chk("seq0", pc_o, 32'h0);
    tick(); chk("seq4", pc_o, 32'h4);
    tick(); chk("seq8", pc_o, 32'h8);
    tick(); chk("seq12", pc_o, 32'hC);
    tick(); chk("seq16", pc_o, 32'h10);

    set_in(1, 0, 1, 32'h200, 0, 0, 0, 0, 0);
    tick(); chk("br", pc_o, 32'h200);
    idle();
    tick(); chk("br_inc", pc_o, 32'h204);

    set_in(1, 1, 1, 32'h300, 0, 0, 0, 0, 0);
    tick(); chk("st1_pc", pc_o, 32'h204);
    chk("st1_pend", {31'd0, redirect_pending_o}, 32'd1);
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("st3_pc", pc_o, 32'h204);
    chk("st3_pend", {31'd0, redirect_pending_o}, 32'd1);
    idle();
    tick(); chk("rel_pc", pc_o, 32'h300);
    chk("rel_pend", {31'd0, redirect_pending_o}, 32'd0);
    tick(); chk("rel_inc", pc_o, 32'h304);

    set_in(1, 1, 0, 0, 1, 32'h100, 1, 0, 0);
    tick();
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick(); chk("trap_pend", {31'd0, redirect_pending_o}, 32'd1);
    idle();
    tick(); chk("trap_pc", pc_o, 32'h80);
    chk("trap_empty", {31'd0, ras_empty_o}, 32'd1);
    tick(); chk("trap_inc", pc_o, 32'h84);

    set_in(1, 0, 0, 0, 1, 32'h0, 0, 0, 0);
    tick(); chk("jmp0", pc_o, 32'h0);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 1, (i + 1) * 32'h100, 1, 0, 0);
      tick(); chk("call_pc", pc_o, (i + 1) * 32'h100);
    end
    chk("ras_full", {31'd0, ras_full_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 1, 32'hABC, 0, 1, 0);
      tick();
      chk("ret_pc", pc_o, (i < 4) ? 32'h404 - i * 32'h100 : 32'hABC);
      if (i == 3) chk("ret_empty", {31'd0, ras_empty_o}, 32'd1);
    end

    set_in(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    tick(); chk("top_pc", pc_o, 32'hFFFF_FFFC);
    idle();
    tick(); chk("wrap", pc_o, 32'h0);

    set_in(0, 0, 1, 32'h700, 0, 0, 0, 0, 0);
    tick(); chk("frz_pc", pc_o, 32'h0);
    set_in(0, 1, 1, 32'h700, 0, 0, 0, 0, 0);
    tick(); chk("frz_pend", {31'd0, redirect_pending_o}, 32'd0);
    idle();
    tick(); chk("frz_rel", pc_o, 32'h4);

    set_in(1, 1, 0, 0, 1, 32'h800, 1, 0, 0);
    tick();
    idle();
    tick(); chk("bcall_pc", pc_o, 32'h800);
    chk("bcall_empty", {31'd0, ras_empty_o}, 32'd0);
    tick();
    set_in(1, 0, 0, 0, 1, 32'h999, 0, 1, 0);
    tick(); chk("bcall_ret", pc_o, 32'h8);

    set_in(1, 1, 1, 32'h600, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 0, 0, 1, 32'h900, 0, 0, 0);
    tick();
    idle();
    tick(); chk("lowpri", pc_o, 32'h600);

    set_in(1, 0, 0, 0, 1, 32'hA00, 1, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 1, 32'hB00, 1, 1, 0);
    tick(); chk("cr_pc", pc_o, 32'h604);
    chk("cr_empty", {31'd0, ras_empty_o}, 32'd0);
    set_in(1, 0, 0, 0, 1, 32'hC00, 0, 1, 0);
    tick(); chk("cr_ret", pc_o, 32'hA04);

    set_in(1, 1, 1, 32'h700, 0, 0, 0, 0, 0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("mrst_pc", pc_o, 32'h0);
    chk("mrst_pend", {31'd0, redirect_pending_o}, 32'd0);
    idle();
    tick();
    rst_i = 1'b1;
    tick(); chk("mrst_inc", pc_o, 32'h4);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
